// File: rtl/rx_fcs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fcs_checker
//  Description : Receive-side CRC-32 FCS checker for the 802.11b 1 Mbps MPDU
//                path. Holds the last 4 bytes in a delay line so that only
//                payload bytes are folded into the CRC. At end of frame it
//                compares the final CRC with the received FCS and reports
//                pass/fail, the length and the short-frame flag.
//                Optional macro FCS_STRIP_EN: when defined, the FCS bytes are
//                removed from the forwarded stream. When undefined, every
//                accepted byte is forwarded with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_fcs_checker #(
   parameter int LEN_W   = 12,
   parameter int MIN_LEN = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   output logic             out_sop,
   output logic             out_eop,
   output logic [7:0]       out_data,
   output logic             fcs_done,
   output logic             fcs_ok,
   output logic             err_short,
   output logic [LEN_W-1:0] frame_len
);

   localparam logic [31:0]      C_POLY     = 32'h04C1_1DB7;
   localparam logic [31:0]      C_CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [LEN_W-1:0] C_LEN_MAX  = '1;
   localparam logic [LEN_W-1:0] C_ONE      = LEN_W'(1);
   localparam logic [LEN_W-1:0] C_FOUR     = LEN_W'(4);
   localparam logic [LEN_W-1:0] C_MIN      = LEN_W'(MIN_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   function automatic logic [7:0] f_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   function automatic logic [31:0] f_rev32(input logic [31:0] b);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = b[31-i];
      return r;
   endfunction

   // MSB-first byte-wise CRC-32 update; the caller supplies the byte already bit-reversed
   function automatic logic [31:0] f_crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {b, 24'h0};
      for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ C_POLY) : (r << 1);
      return r;
   endfunction

   state_t             r_state, w_next_state;
   logic [LEN_W-1:0]   r_count;
   logic [31:0]        r_crc;
   logic [3:0][7:0]    r_dl;          // r_dl[0] is the oldest byte
   logic               r_out_valid, r_out_sop, r_out_eop;
   logic [7:0]         r_out_data;
   logic               r_done, r_ok, r_short;
   logic [LEN_W-1:0]   r_len;

   logic               w_start, w_byte, w_accept, w_end, w_push;
   logic [LEN_W-1:0]   w_cnt_inc, w_len;
   logic               w_short, w_ok;
   logic [31:0]        w_crc_next, w_fin, w_fcs_rx;
   logic               w_fwd_v, w_fwd_sop, w_fwd_eop;
   logic [7:0]         w_fwd_d;

   // Byte qualification, CRC datapath, next state and forwarding selection
   always_comb begin
      w_next_state = r_state;
      w_start      = in_valid & in_sop;
      w_byte       = in_valid & ~in_sop & (r_state != S_IDLE);
      w_accept     = w_start | w_byte;
      w_end        = w_accept & in_eop;
      // The delay line is full once 4 bytes are in, so every later byte pushes one out
      w_push       = w_byte & ((r_state == S_RUN) | (r_count == C_FOUR));
      w_cnt_inc    = (r_count == C_LEN_MAX) ? r_count : (r_count + C_ONE);
      w_len        = w_start ? C_ONE : w_cnt_inc;
      w_short      = (w_len < C_MIN);
      w_crc_next   = w_push ? f_crc_upd(r_crc, f_rev8(r_dl[0])) : r_crc;
      w_fin        = ~f_rev32(w_crc_next);
      // After this cycle's shift the delay line holds the 4 FCS bytes, first one lowest
      w_fcs_rx     = {in_data, r_dl[3], r_dl[2], r_dl[1]};
      w_ok         = ~w_short & (w_fin == w_fcs_rx);

      if (w_end)        w_next_state = S_IDLE;
      else if (w_start) w_next_state = S_FILL;
      else if (w_push)  w_next_state = S_RUN;

`ifdef FCS_STRIP_EN
      w_fwd_v   = w_push;
      w_fwd_d   = r_dl[0];
      w_fwd_sop = w_push & (r_state == S_FILL);
      w_fwd_eop = w_push & in_eop;
`else
      w_fwd_v   = w_accept;
      w_fwd_d   = in_data;
      w_fwd_sop = w_start;
      w_fwd_eop = w_end;
`endif
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Byte counter, CRC register and 4-byte delay line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_crc   <= C_CRC_INIT;
         r_dl    <= '0;
      end else begin
         if (w_start)     r_count <= C_ONE;
         else if (w_byte) r_count <= w_cnt_inc;

         if (w_start | w_end) r_crc <= C_CRC_INIT;
         else if (w_push)     r_crc <= w_crc_next;

         if (w_accept) r_dl <= {in_data, r_dl[3], r_dl[2], r_dl[1]};
      end
   end

   // Registered forwarded stream and per-frame check result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_data  <= 8'h00;
         r_done      <= 1'b0;
         r_ok        <= 1'b0;
         r_short     <= 1'b0;
         r_len       <= '0;
      end else begin
         r_out_valid <= w_fwd_v;
         r_out_sop   <= w_fwd_sop;
         r_out_eop   <= w_fwd_eop;
         r_out_data  <= w_fwd_v ? w_fwd_d : 8'h00;
         r_done      <= w_end;
         r_ok        <= w_end & w_ok;
         r_short     <= w_end & w_short;
         r_len       <= w_end ? w_len : '0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_sop   = r_out_sop;
   assign out_eop   = r_out_eop;
   assign out_data  = r_out_data;
   assign fcs_done  = r_done;
   assign fcs_ok    = r_ok;
   assign err_short = r_short;
   assign frame_len = r_len;

endmodule
`default_nettype wire

// File: tb/tb_rx_fcs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_fcs_checker
//  Description : Self-checking bench for rx_fcs_checker: directed vector
//                table, hand-written corner sequences and random frames
//                compared against a byte-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_fcs_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        out_valid, out_sop, out_eop;
   logic [7:0]  out_data;
   logic        fcs_done, fcs_ok, err_short;
   logic [11:0] frame_len;

   rx_fcs_checker #(.LEN_W(12), .MIN_LEN(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
      .fcs_done(fcs_done), .fcs_ok(fcs_ok), .err_short(err_short), .frame_len(frame_len)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  cur[$];
   bit          act_frame = 0;
   logic        e_ov, e_osop, e_oeop, e_done, e_ok, e_short;
   logic [7:0]  e_od;
   logic [11:0] e_len;
   int          done_cnt = 0;
   logic        last_ok, last_short;
   logic [11:0] last_len;

   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   task automatic model_clear();
      {e_ov, e_osop, e_oeop, e_done, e_ok, e_short} = '0;
      e_od = 8'h00;
      e_len = 12'h000;
   endtask

   task automatic model_step(input logic v, input logic s, input logic e, input logic [7:0] d);
      int n;
      logic [31:0] c;
      model_clear();
      if (rst) begin
         cur.delete();
         act_frame = 0;
         return;
      end
      if (!v) return;
      if (s) begin
         cur.delete();
         act_frame = 1;
      end else if (!act_frame) return;
`ifdef FCS_STRIP_EN
      if (!s && cur.size() >= 4) begin
         e_ov   = 1'b1;
         e_od   = cur[cur.size()-4];
         e_osop = (cur.size() == 4);
         e_oeop = e;
      end
`else
      e_ov = 1'b1; e_od = d; e_osop = s; e_oeop = e;
`endif
      cur.push_back(d);
      if (e) begin
         n       = cur.size();
         e_done  = 1'b1;
         e_len   = (n > 4095) ? 12'hFFF : 12'(n);
         e_short = (n < 5);
         if (n >= 5) begin
            c = 32'hFFFF_FFFF;
            for (int i = 0; i < n - 4; i++) c = crc_ref(c, cur[i]);
            e_ok = (~c == {cur[n-1], cur[n-2], cur[n-3], cur[n-4]});
         end
         act_frame = 0;
      end
   endtask

   task automatic check_all();
      chk("stream", {out_valid, out_sop, out_eop, out_data}, {e_ov, e_osop, e_oeop, e_od});
      chk("result", {fcs_done, fcs_ok, err_short, frame_len}, {e_done, e_ok, e_short, e_len});
      if (fcs_done) begin
         done_cnt++;
         last_ok = fcs_ok; last_short = err_short; last_len = frame_len;
      end
   endtask

   // Drive one cycle of input (called at the falling edge), model it, check at the next falling edge
   task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d);
      in_valid = v; in_sop = s; in_eop = e; in_data = d;
      @(posedge clk);
      model_step(v, s, e, d);
      @(negedge clk);
      check_all();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic v, s, e;
      logic [7:0] d;
      logic xd, xo, xs;
      logic [11:0] xl;
   } vec_t;
   vec_t tbl[$];
   logic [7:0] t1 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                           8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

   task automatic add(input logic v, input logic s, input logic e, input logic [7:0] d,
                      input logic xd, input logic xo, input logic xs, input logic [11:0] xl);
      vec_t r;
      r.v = v; r.s = s; r.e = e; r.d = d; r.xd = xd; r.xo = xo; r.xs = xs; r.xl = xl;
      tbl.push_back(r);
   endtask

   task automatic add_t1(input bit bad_last);
      for (int i = 0; i < 13; i++) begin
         if (i == 12) add(1, 0, 1, bad_last ? 8'hCA : t1[i], 1, !bad_last, 0, 12'd13);
         else         add(1, i == 0, 0, t1[i], 0, 0, 0, 12'd0);
      end
      add(0, 0, 0, 8'h00, 0, 0, 0, 12'd0);
   endtask

   // Send a frame with optional FCS generation, random gaps and early abort
   task automatic send_frame(input int n, input bit good, input int gap, input int abort_at);
      logic [7:0] q[$];
      logic [31:0] c;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if (good && n >= 5) begin
         c = 32'hFFFF_FFFF;
         for (int i = 0; i < n - 4; i++) c = crc_ref(c, q[i]);
         c = ~c;
         q[n-4] = c[7:0]; q[n-3] = c[15:8]; q[n-2] = c[23:16]; q[n-1] = c[31:24];
      end
      for (int i = 0; i < n; i++) begin
         if (abort_at != 0 && i == abort_at) break;
         while (int'($urandom_range(0, 99)) < gap)
            step(0, 1'($urandom), 1'($urandom), 8'($urandom));
         step(1, i == 0, i == n - 1, q[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      check_all();
      chk("reset_outputs", {out_valid, out_sop, out_eop, out_data, fcs_done, fcs_ok, err_short, frame_len}, '0);
      rst = 1'b0;

      // Tests 1-4 through the table: good frame, bad FCS, 4-byte short, aborted frame then good
      add_t1(0);
      add_t1(1);
      for (int i = 0; i < 4; i++) add(1, i == 0, i == 3, 8'h00, i == 3, 0, i == 3, (i == 3) ? 12'd4 : 12'd0);
      add(0, 0, 0, 8'h00, 0, 0, 0, 12'd0);
      for (int i = 0; i < 6; i++) add(1, i == 0, 0, 8'hA0 + 8'(i), 0, 0, 0, 12'd0);
      add_t1(0);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
         chk($sformatf("table[%0d]", i), {fcs_done, fcs_ok, err_short, frame_len},
             {tbl[i].xd, tbl[i].xo, tbl[i].xs, tbl[i].xl});
      end

      // Test 5: valid high one cycle in three
      d0 = done_cnt;
      for (int i = 0; i < 13; i++) begin
         step(1, i == 0, i == 12, t1[i]);
         if (i != 12) begin
            step(0, 0, 0, 8'hEE);
            step(0, 1, 1, 8'h55);
         end
      end
      step(0, 0, 0, 8'h00);
      chk("gap_done_count", 64'(done_cnt - d0), 1);
      chk("gap_result", {last_ok, last_short, last_len}, {1'b1, 1'b0, 12'd13});

      // Test 6: reset after byte 7 abandons the frame, the next frame passes
      d0 = done_cnt;
      for (int i = 0; i < 7; i++) step(1, i == 0, 0, t1[i]);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {out_valid, out_sop, out_eop, out_data, fcs_done, fcs_ok, err_short, frame_len}, '0);
      step(0, 0, 0, 8'h00);
      rst = 1'b0;
      step(0, 0, 0, 8'h00);
      chk("reset_no_done", 64'(done_cnt - d0), 0);
      for (int i = 0; i < 13; i++) step(1, i == 0, i == 12, t1[i]);
      step(0, 0, 0, 8'h00);
      chk("after_reset_done_count", 64'(done_cnt - d0), 1);
      chk("after_reset_result", {last_ok, last_short, last_len}, {1'b1, 1'b0, 12'd13});

      // Shortest legal frame and a frame past the length saturation point
      send_frame(5, 1, 0, 0);
      step(0, 0, 0, 8'h00);
      chk("len5_result", {last_ok, last_short, last_len}, {1'b1, 1'b0, 12'd5});
      send_frame(4100, 1, 0, 0);
      step(0, 0, 0, 8'h00);
      chk("saturated_result", {last_ok, last_short, last_len}, {1'b1, 1'b0, 12'hFFF});

      // Random frames: mixed lengths, good/bad FCS, gaps, aborts and stray bytes
      for (int k = 0; k < 80; k++) begin
         int n;
         n = int'($urandom_range(1, 24));
         send_frame(n, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 50)),
                    (n > 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, n - 1)) : 0);
         if ($urandom_range(0, 4) == 0) step(1, 0, 1'($urandom), 8'($urandom));
         if ($urandom_range(0, 1) == 0) step(0, 0, 0, 8'h00);
      end
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
